// File: rtl/edge_router_pkg.sv
// edge_router_pkg: shared defaults and width helper for the edge router blocks
package edge_router_pkg;
  localparam int EDGE_DATA_WIDTH = 32;
  localparam int EDGE_NUM_SRC = 32;
  function automatic int src_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter import edge_router_pkg::*; #(
  parameter int N = EDGE_NUM_SRC
) (
  input  logic [N-1:0]          req,
  input  logic [src_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [src_w(N)-1:0]   gnt_idx,
  output logic                  any
);
  localparam int W = src_w(N);
  int k;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    k = 0;
    // walk offsets from farthest to nearest so the nearest requester wins
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_idx = W'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/edge_read_arbiter.sv
// edge_read_arbiter: round-robin read-return arbiter feeding one registered egress word
// Define EDGE_ARB_SRC_TAG_EN to add the src_o source-index tag.
module edge_read_arbiter import edge_router_pkg::*; #(
  parameter int NUM_SRC = EDGE_NUM_SRC,
  parameter int DATA_WIDTH = EDGE_DATA_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC-1:0]            read_valid_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] data_i,
  output logic [NUM_SRC-1:0]            read_ready_o,
  output logic                          read_valid_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic                          read_ready_i
`ifdef EDGE_ARB_SRC_TAG_EN
  ,
  output logic [src_w(NUM_SRC)-1:0]     src_o
`endif
);
  localparam int SRC_W = src_w(NUM_SRC);
  logic [SRC_W-1:0] r_ptr, w_gnt_idx, w_ptr_nxt;
  logic [NUM_SRC-1:0] w_gnt;
  logic [DATA_WIDTH-1:0] r_data, w_word;
  logic r_valid, w_any, w_load_ok, w_accept;
  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req(read_valid_i),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .gnt_idx(w_gnt_idx),
    .any(w_any)
  );
  always_comb begin
    w_load_ok = !r_valid || read_ready_i;
    w_accept = w_any && w_load_ok && !rst_i;
    read_ready_o = w_accept ? w_gnt : '0;
    w_word = data_i[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    w_ptr_nxt = (int'(w_gnt_idx) == NUM_SRC - 1) ? '0 : w_gnt_idx + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_ptr <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data <= w_word;
      r_ptr <= w_ptr_nxt;
    end else if (read_ready_i) begin
      r_valid <= 1'b0;
    end
  end
`ifdef EDGE_ARB_SRC_TAG_EN
  logic [SRC_W-1:0] r_src;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_src <= '0;
    else if (w_accept) r_src <= w_gnt_idx;
  end
  assign src_o = r_src;
`endif
  assign read_valid_o = r_valid;
  assign data_o = r_data;
endmodule

// File: tb/tb_edge_read_arbiter.sv
// tb_edge_read_arbiter: directed checks of grant order, backpressure and reset
module tb_edge_read_arbiter;
  localparam int N = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_i;
  logic [N-1:0] read_valid_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0] read_ready_o;
  logic read_valid_o;
  logic [DW-1:0] data_o;
  logic read_ready_i;
  int checks = 0;
  int errors = 0;
`ifdef EDGE_ARB_SRC_TAG_EN
  logic [4:0] src_o;
`endif

  edge_read_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .read_valid_i(read_valid_i),
    .data_i(data_i),
    .read_ready_o(read_ready_o),
    .read_valid_o(read_valid_o),
    .data_o(data_o),
    .read_ready_i(read_ready_i)
`ifdef EDGE_ARB_SRC_TAG_EN
    ,
    .src_o(src_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic word(input int k, input logic [DW-1:0] w);
    data_i[k*DW +: DW] = w;
  endtask

  task automatic chk_src(input string tag, input int exp);
`ifdef EDGE_ARB_SRC_TAG_EN
    chk(tag, 64'(src_o), 64'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    read_ready_i = 1'b1;
    read_valid_i = '1;
    data_i = '0;
    for (int k = 0; k < N; k++) word(k, DW'(32'h1000 + k));
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_valid", 64'(read_valid_o), 64'd0);
      chk("rst_data", 64'(data_o), 64'd0);
      chk("rst_ready", 64'(read_ready_o), 64'd0);
      chk_src("rst_src", 0);
    end
    rst_i = 1'b0;
    #1;
    chk("first_grant", 64'(read_ready_o), 64'h1);
    for (int i = 0; i < 33; i++) begin
      chk("full_ready", 64'(read_ready_o), 64'(32'h1 << (i % N)));
      tick();
      chk("full_data", 64'(data_o), 64'(32'h1000 + (i % N)));
      chk("full_valid", 64'(read_valid_o), 64'd1);
      chk_src("full_src", i % N);
    end
    read_valid_i = '0;
    tick();
    chk("drain_valid", 64'(read_valid_o), 64'd0);
    read_valid_i[5] = 1'b1;
    word(5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 64'(read_ready_o), 64'h20);
    tick();
    read_valid_i = '0;
    #1;
    chk("single_data", 64'(data_o), 64'hDEADBEEF);
    chk("single_valid", 64'(read_valid_o), 64'd1);
    chk("single_ready_off", 64'(read_ready_o), 64'd0);
    chk_src("single_src", 5);
    tick();
    chk("single_gone", 64'(read_valid_o), 64'd0);
    read_valid_i[10] = 1'b1;
    word(10, 32'hA5A5A5A5);
    #1;
    chk("bp_ready0", 64'(read_ready_o), 64'(32'h1 << 10));
    tick();
    read_valid_i = '0;
    read_valid_i[12] = 1'b1;
    word(12, 32'h12121212);
    read_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_data", 64'(data_o), 64'hA5A5A5A5);
      chk("bp_valid", 64'(read_valid_o), 64'd1);
      chk("bp_ready", 64'(read_ready_o), 64'd0);
      chk_src("bp_src", 10);
      tick();
    end
    read_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 64'(read_ready_o), 64'(32'h1 << 12));
    tick();
    read_valid_i = '0;
    chk("bp_release_data", 64'(data_o), 64'h12121212);
    chk_src("bp_release_src", 12);
    for (int k = 0; k < N; k++) word(k, DW'(32'h3000 + k));
    read_valid_i[30] = 1'b1;
    #1;
    chk("wrap_ready30", 64'(read_ready_o), 64'(32'h1 << 30));
    tick();
    read_valid_i = '0;
    read_valid_i[31] = 1'b1;
    read_valid_i[0] = 1'b1;
    #1;
    chk("wrap_data30", 64'(data_o), 64'h301E);
    chk("wrap_ready31", 64'(read_ready_o), 64'(32'h1 << 31));
    tick();
    read_valid_i[31] = 1'b0;
    #1;
    chk("wrap_data31", 64'(data_o), 64'h301F);
    chk("wrap_ready0", 64'(read_ready_o), 64'h1);
    tick();
    read_valid_i = '0;
    chk("wrap_data0", 64'(data_o), 64'h3000);
    chk_src("wrap_src0", 0);
    read_valid_i[7] = 1'b1;
    tick();
    read_valid_i = '0;
    read_ready_i = 1'b0;
    chk("mid_valid", 64'(read_valid_o), 64'd1);
    chk("mid_data", 64'(data_o), 64'h3007);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_valid", 64'(read_valid_o), 64'd0);
    chk("mid_rst_data", 64'(data_o), 64'd0);
    chk_src("mid_rst_src", 0);
    read_ready_i = 1'b1;
    read_valid_i[0] = 1'b1;
    read_valid_i[9] = 1'b1;
    #1;
    chk("mid_rst_ptr", 64'(read_ready_o), 64'h1);
    tick();
    read_valid_i = '0;
    chk("mid_rst_next", 64'(data_o), 64'h3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_read_arbiter.md
# edge_read_arbiter

Registered, round-robin read-return arbiter for the NoC edge router. Multiple read sources present words with valid/ready handshakes and one source per cycle is granted. The granted word is loaded into a single output register and presented to the router's egress with valid/ready backpressure. Unlike a combinational OR-collapse, it tolerates multiple simultaneous valid sources, preserves every word and guarantees fairness.

## Interface
Parameters:
- NUM_SRC, 32: number of read sources; legal range 1 to 64.
- DATA_WIDTH, 32: bits per word.
- SRC_W, max(1, $clog2(NUM_SRC)): source-index width. Derived; must not be overridden.

Ports:
- clk_i, input, 1: single clock; all state updates on its rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- read_valid_i, input, NUM_SRC: per-source word-valid.
- data_i, input, NUM_SRC*DATA_WIDTH: source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- read_ready_o, output, NUM_SRC: per-source accept; at most one bit set.
- read_valid_o, output, 1: output register holds a word.
- data_o, output, DATA_WIDTH: registered word.
- read_ready_i, input, 1: egress accepts data_o.
- src_o, output, SRC_W: index of the source that supplied data_o. Present only with EDGE_ARB_SRC_TAG_EN.

## Operation
- State:
  - Round-robin pointer ptr (SRC_W bits).
  - Output register: valid, data, and src when the tag feature is compiled in.
- load_ok = !read_valid_o | read_ready_i.
- Grant g is the first k with read_valid_i[k]=1, searching ptr, ptr+1, …, NUM_SRC-1, 0, …, ptr-1. The search is combinational.
- read_ready_o[g] = load_ok when any source is valid; all other bits are 0.
- Accept occurs when read_valid_i[g] & read_ready_o[g]:
  - Next cycle: data_o = word g, read_valid_o = 1.
  - src_o = g when the tag feature is compiled in.
  - ptr = g+1, wrapping NUM_SRC-1 to 0.
- No accept, but egress drains (read_valid_o & read_ready_i): read_valid_o = 0 next cycle.
- No accept, no drain: output register and ptr hold.
- Source protocol: once read_valid_i[k] rises it stays high with data stable until accepted. The arbiter never drops a presented word.
- read_ready_o depends combinationally on read_valid_i and read_ready_i. Sources must not make read_valid_i depend on read_ready_o.
- NUM_SRC=1: ptr is constant 0; the block degenerates to a one-entry pipeline register.

## Timing
- Reset values: read_valid_o=0, data_o=0, src_o=0, ptr=0, read_ready_o=0 (no valids are in flight during reset).
- Latency: 1 cycle from accept edge to read_valid_o=1.
- Throughput: one word per cycle with read_ready_i held high. Accept and drain in the same cycle are legal; the register reloads with no bubble.
- Backpressure: while read_valid_o & !read_ready_i:
  - data_o and src_o are stable.
  - read_ready_o is all zero.
  - ptr holds.
- All NUM_SRC sources valid with read_ready_i=1: grants run 0,1,…,NUM_SRC-1,0,… with one per cycle. No source waits more than NUM_SRC-1 grants.
- Reset asserted mid-transfer takes priority over all other updates:
  - The held word is discarded.
  - Outputs and ptr return to their reset values on the next edge.
- A source that deasserts read_valid_i without acceptance violates protocol. Behaviour is defined only in that the arbiter re-searches on the next cycle.

## Configuration
- EDGE_ARB_SRC_TAG_EN defined:
  - src_o port and src register exist.
  - src_o is updated with data_o on each accept and reset to 0.
- Not defined:
  - src_o and its register are absent.
  - Arbitration and data behaviour are identical.

## Structure
- Shared package edge_router_pkg holds:
  - EDGE_DATA_WIDTH and EDGE_NUM_SRC default constants.
  - Function src_w(n) returning max(1, $clog2(n)).
- One sub-module is natural: rr_arbiter (parameter N).
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], gnt_idx, any.
  - Purely combinational.
- ptr and the output register stay in edge_read_arbiter.

## Test plan
- Reset: hold rst_i 2 cycles with all read_valid_i=1 → read_valid_o=0, data_o=0, read_ready_o=0 throughout. First grant after release goes to source 0.
- Single source: NUM_SRC=32, only source 5 valid with word 0xDEADBEEF, read_ready_i=1 → read_ready_o=0x20 for one cycle. Next cycle: data_o=0xDEADBEEF, src_o=5. The following cycle read_valid_o=0.
- Full-load fairness: all 32 sources valid, word k = 0x1000+k, read_ready_i=1 → 32 consecutive output words 0x1000…0x101F. Then wrap to 0x1000 with no gaps.
- Backpressure: read_ready_i=0 for 4 cycles with data_o=0xA5A5A5A5 held → data_o is stable and read_ready_o=0 throughout. On release, the next granted word appears one cycle later.
- Wrap-around: ptr=31 after grant to 30; sources 31 and 0 valid → 31 is granted, then 0.
- Reset mid-transfer: assert rst_i while read_valid_o=1 and read_ready_i=0 → read_valid_o=0 next cycle, word discarded, ptr=0.
